cache_refill_arbiter: RTL and testbench
=======================================

Name: cache_refill_arbiter

Overview:
Shares one AXI4 read channel between the ICache line-refill port and the DCache line-refill port. Grants one requester at a time and issues an 8-beat INCR burst for the 32-byte line. Assembles the returned beats into a 256-bit line and hands it back to the granted cache with a single-cycle rvalid pulse. Sits between the two L1 caches and the top-level AXI master interface.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, AXI data width (one instruction/word per beat)
LINE_WORDS, 8, words per cache line (burst length = LINE_WORDS)
ID_I, 4'd0, arid used for ICache refills
ID_D, 4'd1, arid used for DCache refills

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
icache_ren_i  in  1  ICache miss request; level, held until icache_rvalid_o
icache_araddr_i  in  32  ICache miss address; stable while icache_ren_i high
icache_rvalid_o  out  1  one-cycle pulse: icache_rdata_o valid
icache_rdata_o  out  256  refilled line; word k at bits [32k+31:32k]
dcache_ren_i  in  1  DCache miss request; level
dcache_araddr_i  in  32  DCache miss address
dcache_rvalid_o  out  1  one-cycle pulse: dcache_rdata_o valid
dcache_rdata_o  out  256  refilled line, same packing
arid  out  4  read ID
araddr  out  32  line-aligned burst address
arlen  out  8  constant LINE_WORDS-1 (8'd7)
arsize  out  3  constant 3'b010
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  R data
rresp  in  2  R response (not checked)
rlast  in  1  last beat
rvalid  in  1  R valid
rready  out  1  R ready
busy_o  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, AR, R, RESP. Reset -> IDLE. All outputs 0 in reset, except arlen/arsize/arburst constants. Line buffer cleared; last_grant = DCACHE.
- IDLE:
  - No request -> stay in IDLE.
  - Exactly one request -> grant that requester.
  - Both requesting -> grant the one not in last_grant (round-robin). After reset, ICache wins the first tie.
  - On grant: latch requester, address {addr[31:5],5'b0}, and arid. Go to AR the next cycle; update last_grant.
- AR: arvalid=1; araddr/arid held constant until arready. On arvalid&arready -> R; beat counter cnt=0.
- R: rready=1.
  - Each rvalid&rready writes rdata into buffer word cnt, then cnt++ (3-bit, wraps).
  - A beat with rlast=1 -> RESP. No early exit without rlast.
  - Beats after the 8th without rlast overwrite from word 0 (wrap). This is not an error.
- RESP (exactly 1 cycle), then IDLE:
  - {grant}_rvalid_o = 1 only if that requester's ren is still high and its araddr[31:5] equals the latched tag.
  - Otherwise the line is discarded (requester flushed/changed) and no pulse is issued. The new request is re-arbitrated from IDLE.
- rdata outputs: driven from the line buffer continuously; meaningful only during the pulse.
- Request-to-rvalid latency with zero-wait slave (arready and rvalid always high): grant cycle + AR cycle + 8 R beats + RESP = pulse 11 cycles after ren is first sampled in IDLE.
- A request arriving while busy waits; requests are only sampled in IDLE.
- The non-granted requester's rvalid stays 0 throughout.
- Reset mid-operation: immediate return to IDLE, arvalid/rready drop, no rvalid pulse. The AXI slave shares rst.
- rvalid_o is never asserted in the same cycle ren is first raised (no combinational path from ren to rvalid_o).

Test Plan:
- ICache only, addr 0x1FC0_0024, zero-wait slave returning 0x100..0x107 -> araddr 0x1FC0_0020, arlen 7, arid 0. icache_rvalid_o pulses 11 cycles after request; icache_rdata_o word k = 0x100+k.
- ICache and DCache raise requests in the same cycle after reset -> ICache served first, DCache second. Back-to-back simultaneous requests then alternate D, I.
- arready delayed 5 cycles, random rvalid gaps -> araddr/arvalid stable while waiting. Data is assembled correctly; exactly one pulse per line.
- ICache drops ren during R (flush) -> burst completes, no icache_rvalid_o, return to IDLE. A new ICache request at 0x0000_0040 is then served normally.
- rst asserted mid-burst after 3 beats -> next cycle IDLE, arvalid=0, rready=0, busy_o=0. No rvalid pulse.
- Slave returns rlast on the 8th beat with rresp=SLVERR -> data still delivered with a normal pulse.

Source files
------------

// File: rtl/cache_refill_arbiter_if.sv
// AXI4 read-address / read-data channel bundle used between the refill
// arbiter (master) and the top-level AXI read port or a slave model.
//   master : drives arid/araddr/arlen/arsize/arburst/arvalid and rready
//   slave  : drives arready and rdata/rresp/rlast/rvalid
interface cache_refill_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/cache_refill_arbiter.sv
// Shares one AXI4 read channel between the ICache and DCache line-refill
// ports. One requester is granted at a time (round-robin on ties), an
// INCR burst of LINE_WORDS beats fetches the aligned line, the beats are
// assembled into a line buffer and handed back with a one-cycle rvalid.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   icache_ren_i / icache_araddr_i ICache miss request (level) and address
//   icache_rvalid_o / icache_rdata_o  refill pulse and line for ICache
//   dcache_ren_i / dcache_araddr_i DCache miss request (level) and address
//   dcache_rvalid_o / dcache_rdata_o  refill pulse and line for DCache
//   axi                            AXI read channel (master modport)
//   busy_o                         high whenever the FSM is not idle
module cache_refill_arbiter #(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] ID_I       = 4'd0,
    parameter logic [3:0] ID_D       = 4'd1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         icache_ren_i,
    input  logic [ADDR_W-1:0]            icache_araddr_i,
    output logic                         icache_rvalid_o,
    output logic [LINE_WORDS*DATA_W-1:0] icache_rdata_o,
    input  logic                         dcache_ren_i,
    input  logic [ADDR_W-1:0]            dcache_araddr_i,
    output logic                         dcache_rvalid_o,
    output logic [LINE_WORDS*DATA_W-1:0] dcache_rdata_o,
    cache_refill_arbiter_if.master       axi,
    output logic                         busy_o
);
    localparam int LINE_W = LINE_WORDS * DATA_W;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int CNT_W  = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_RESP
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    // Current grant and round-robin history share one flop: it is only
    // rewritten on a new grant, so between grants it is the last winner.
    logic                     r_gnt_d;
    logic [ADDR_W-1:OFF_W]    r_tag;
    logic [3:0]               r_id;
    logic [CNT_W-1:0]         r_cnt;
    logic [LINE_W-1:0]        r_line;
    logic                     r_ivalid;
    logic                     r_dvalid;

    logic                     w_grant;
    logic                     w_pick_d;
    logic                     w_beat;
    logic                     w_match_i;
    logic                     w_match_d;
    logic                     w_unused;

    // Response code and in-line offset bits carry no information here.
    assign w_unused = ^{axi.rresp, icache_araddr_i[OFF_W-1:0],
                        dcache_araddr_i[OFF_W-1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_pick_d    = 1'b0;
        w_beat      = (r_state == ST_R) && axi.rvalid;
        w_match_i   = icache_ren_i && (icache_araddr_i[ADDR_W-1:OFF_W] == r_tag);
        w_match_d   = dcache_ren_i && (dcache_araddr_i[ADDR_W-1:OFF_W] == r_tag);
        case (r_state)
            ST_IDLE: begin
                if (icache_ren_i || dcache_ren_i) begin
                    w_grant     = 1'b1;
                    // DCache wins when alone, or on a tie if ICache won last.
                    w_pick_d    = dcache_ren_i && (!icache_ren_i || !r_gnt_d);
                    w_state_nxt = ST_AR;
                end
            end
            ST_AR: begin
                if (axi.arready) begin
                    w_state_nxt = ST_R;
                end
            end
            ST_R: begin
                if (w_beat && axi.rlast) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt_d  <= 1'b1;
            r_tag    <= '0;
            r_id     <= '0;
            r_cnt    <= '0;
            r_line   <= '0;
            r_ivalid <= 1'b0;
            r_dvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ivalid <= 1'b0;
            r_dvalid <= 1'b0;
            if (w_grant) begin
                r_gnt_d <= w_pick_d;
                r_tag   <= w_pick_d ? dcache_araddr_i[ADDR_W-1:OFF_W]
                                    : icache_araddr_i[ADDR_W-1:OFF_W];
                r_id    <= w_pick_d ? ID_D : ID_I;
            end
            if ((r_state == ST_AR) && axi.arready) begin
                r_cnt <= '0;
            end
            if (w_beat) begin
                r_line[r_cnt*DATA_W +: DATA_W] <= axi.rdata;
                r_cnt                          <= r_cnt + 1'b1;
                // The pulse is registered on the last beat so that it lands in
                // the RESP cycle without any combinational path from ren.
                if (axi.rlast) begin
                    r_ivalid <= !r_gnt_d && w_match_i;
                    r_dvalid <=  r_gnt_d && w_match_d;
                end
            end
        end
    end

    assign axi.arid    = r_id;
    assign axi.araddr  = {r_tag, {OFF_W{1'b0}}};
    assign axi.arlen   = 8'(LINE_WORDS - 1);
    assign axi.arsize  = 3'($clog2(DATA_W / 8));
    assign axi.arburst = 2'b01;
    assign axi.arvalid = (r_state == ST_AR);
    assign axi.rready  = (r_state == ST_R);

    assign busy_o          = (r_state != ST_IDLE);
    assign icache_rvalid_o = r_ivalid;
    assign dcache_rvalid_o = r_dvalid;
    assign icache_rdata_o  = r_line;
    assign dcache_rdata_o  = r_line;
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter with a behavioural AXI read slave.
module tb_cache_refill_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         icache_ren_i;
    logic [31:0]  icache_araddr_i;
    logic         icache_rvalid_o;
    logic [255:0] icache_rdata_o;
    logic         dcache_ren_i;
    logic [31:0]  dcache_araddr_i;
    logic         dcache_rvalid_o;
    logic [255:0] dcache_rdata_o;
    logic         busy_o;

    cache_refill_arbiter_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    cache_refill_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LINE_WORDS(8), .ID_I(4'd0), .ID_D(4'd1)
    ) dut (
        .clk(clk), .rst(rst),
        .icache_ren_i(icache_ren_i), .icache_araddr_i(icache_araddr_i),
        .icache_rvalid_o(icache_rvalid_o), .icache_rdata_o(icache_rdata_o),
        .dcache_ren_i(dcache_ren_i), .dcache_araddr_i(dcache_araddr_i),
        .dcache_rvalid_o(dcache_rvalid_o), .dcache_rdata_o(dcache_rdata_o),
        .axi(axi), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected line: beat k lands in word k mod 8.
    function automatic logic [255:0] make_line(input logic [31:0] base, input int unsigned nb);
        logic [255:0] l;
        l = '0;
        for (int unsigned k = 0; k < nb; k++) l[(k % 8)*32 +: 32] = base + k;
        return l;
    endfunction

    // ---------------- AXI read slave model ----------------
    int unsigned s_ar_delay = 0;
    int unsigned s_nbeats   = 8;
    bit          s_gaps     = 0;
    logic [1:0]  s_resp     = 2'b00;
    logic [31:0] s_base_fixed = '0;   // 0: data = araddr + k
    logic [31:0] s_base;
    logic [31:0] s_ar_addr = '0;
    logic [3:0]  s_ar_id   = '0;
    logic [7:0]  s_ar_len  = '0;
    int unsigned s_wait, s_beat;
    bit          s_phase;

    task automatic slave_drive();
        if (s_gaps && ($urandom_range(0, 2) == 0)) begin
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
        end else begin
            axi.rvalid = 1'b1;
            axi.rdata  = s_base + s_beat;
            axi.rresp  = s_resp;
            axi.rlast  = (s_beat == s_nbeats - 1);
        end
    endtask

    initial begin
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
        axi.rdata = '0; axi.rresp = '0;
        s_phase = 0; s_wait = 0; s_beat = 0; s_base = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
                s_phase = 0; s_wait = 0; s_beat = 0;
            end else if (!s_phase) begin
                if (axi.arready) begin
                    // arready was up across the last posedge with arvalid held.
                    axi.arready = 1'b0;
                    s_phase = 1; s_beat = 0; s_wait = 0;
                    slave_drive();
                end else if (axi.arvalid) begin
                    if (s_wait >= s_ar_delay) begin
                        axi.arready = 1'b1;
                        s_ar_addr = axi.araddr;
                        s_ar_id   = axi.arid;
                        s_ar_len  = axi.arlen;
                        s_base    = (s_base_fixed != 0) ? s_base_fixed : axi.araddr;
                    end else begin
                        s_wait++;
                    end
                end
            end else begin
                if (axi.rvalid) s_beat++;
                if (s_beat >= s_nbeats) begin
                    axi.rvalid = 1'b0; axi.rlast = 1'b0;
                    s_phase = 0; s_wait = 0;
                end else begin
                    slave_drive();
                end
            end
        end
    end

    // ---------------- pulse monitor ----------------
    int unsigned tot_i = 0, tot_d = 0;
    initial forever begin
        @(negedge clk);
        if (icache_rvalid_o) tot_i++;
        if (dcache_rvalid_o) tot_d++;
    end

    // ---------------- stimulus helpers ----------------
    int           order[$];
    logic [255:0] line_i, line_d;
    int unsigned  lat_i, lat_d;

    // Runs until the wanted pulses arrive; each requester drops ren on its pulse.
    task automatic wait_pulses(input int unsigned want_i, input int unsigned want_d,
                               input int unsigned budget, input string tag);
        int unsigned gi = 0, gd = 0, n = 0;
        while ((gi < want_i || gd < want_d) && n < budget) begin
            @(posedge clk); #1; n++;
            if (icache_rvalid_o) begin
                gi++; line_i = icache_rdata_o; lat_i = n; order.push_back(0); icache_ren_i = 1'b0;
            end
            if (dcache_rvalid_o) begin
                gd++; line_d = dcache_rdata_o; lat_d = n; order.push_back(1); dcache_ren_i = 1'b0;
            end
        end
        check_val({tag, "_pulses"}, gi + gd, want_i + want_d);
    endtask

    task automatic wait_rready(input string tag);
        int unsigned n = 0;
        while (!axi.rready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check_val({tag, "_rready"}, axi.rready, 1'b1);
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int unsigned b_i, b_d, ar_cyc, stab_bad, nn;

    initial begin
        rst = 1'b1;
        icache_ren_i = 1'b0; icache_araddr_i = '0;
        dcache_ren_i = 1'b0; dcache_araddr_i = '0;
        cycles(3);

        // Reset state
        check_val("rst_busy", busy_o, 1'b0);
        check_val("rst_arvalid", axi.arvalid, 1'b0);
        check_val("rst_rready", axi.rready, 1'b0);
        check_val("rst_rvalid", {icache_rvalid_o, dcache_rvalid_o}, 2'b00);
        check_val("rst_araddr", axi.araddr, 32'h0);
        check_val("rst_arlen", axi.arlen, 8'd7);
        check_val("rst_arsize", axi.arsize, 3'b010);
        check_val("rst_arburst", axi.arburst, 2'b01);
        check_val("rst_line", icache_rdata_o, 256'h0);
        rst = 1'b0;
        cycles(1);

        // Simultaneous first requests after reset: ICache first, then DCache.
        order.delete();
        icache_araddr_i = 32'h0000_1004; dcache_araddr_i = 32'h0000_2008;
        icache_ren_i = 1'b1; dcache_ren_i = 1'b1;
        wait_pulses(1, 1, 60, "tie0");
        check_val("tie0_first", order[0], 0);
        check_val("tie0_second", order[1], 1);
        check_val("tie0_lat_i", lat_i, 10);
        check_val("tie0_lat_d", lat_d, 21);
        check_val("tie0_line_i", line_i, make_line(32'h0000_1000, 8));
        check_val("tie0_line_d", line_d, make_line(32'h0000_2000, 8));
        cycles(2);

        // ICache alone, zero-wait slave, fixed data 0x100+k.
        // The pulse falls in the 11th cycle counting the grant cycle as the 1st.
        b_i = tot_i; b_d = tot_d;
        s_base_fixed = 32'h100;
        icache_araddr_i = 32'h1FC0_0024; icache_ren_i = 1'b1;
        wait_pulses(1, 0, 30, "ionly");
        check_val("ionly_lat", lat_i, 10);
        check_val("ionly_araddr", s_ar_addr, 32'h1FC0_0020);
        check_val("ionly_arid", s_ar_id, 4'd0);
        check_val("ionly_arlen", s_ar_len, 8'd7);
        check_val("ionly_line", line_i, make_line(32'h100, 8));
        s_base_fixed = '0;
        cycles(3);
        check_val("ionly_cnt_i", tot_i - b_i, 1);
        check_val("ionly_cnt_d", tot_d - b_d, 0);
        check_val("ionly_idle", busy_o, 1'b0);

        // Tie after an ICache grant: DCache first, then ICache.
        order.delete();
        icache_araddr_i = 32'h0000_3000; dcache_araddr_i = 32'h0000_4020;
        icache_ren_i = 1'b1; dcache_ren_i = 1'b1;
        wait_pulses(1, 1, 60, "tie1");
        check_val("tie1_first", order[0], 1);
        check_val("tie1_second", order[1], 0);
        check_val("tie1_line_d", line_d, make_line(32'h0000_4020, 8));
        cycles(2);

        // DCache with delayed arready and random rvalid gaps.
        b_i = tot_i; b_d = tot_d;
        s_ar_delay = 5; s_gaps = 1;
        ar_cyc = 0; stab_bad = 0; nn = 0;
        dcache_araddr_i = 32'h8000_0044; dcache_ren_i = 1'b1;
        while (dcache_ren_i && nn < 200) begin
            @(posedge clk); #1; nn++;
            if (axi.arvalid) begin
                ar_cyc++;
                if (axi.araddr !== 32'h8000_0040 || axi.arid !== 4'd1) stab_bad++;
            end
            if (dcache_rvalid_o) begin
                line_d = dcache_rdata_o; dcache_ren_i = 1'b0;
            end
        end
        check_val("slow_done", dcache_ren_i, 1'b0);
        check_val("slow_ar_cycles", ar_cyc, 6);
        check_val("slow_ar_stable", stab_bad, 0);
        check_val("slow_line", line_d, make_line(32'h8000_0040, 8));
        s_ar_delay = 0; s_gaps = 0;
        cycles(5);
        check_val("slow_cnt_d", tot_d - b_d, 1);
        check_val("slow_cnt_i", tot_i - b_i, 0);

        // ICache flush during R: burst completes, no pulse.
        b_i = tot_i;
        icache_araddr_i = 32'h0000_5000; icache_ren_i = 1'b1;
        wait_rready("flush");
        cycles(2);
        icache_ren_i = 1'b0;
        cycles(20);
        check_val("flush_no_pulse", tot_i - b_i, 0);
        check_val("flush_idle", busy_o, 1'b0);
        icache_araddr_i = 32'h0000_0040; icache_ren_i = 1'b1;
        wait_pulses(1, 0, 30, "after_flush");
        check_val("after_flush_line", line_i, make_line(32'h0000_0040, 8));
        check_val("after_flush_araddr", s_ar_addr, 32'h0000_0040);

        // Address changes during R with ren held: line discarded, re-arbitrated.
        cycles(2);
        b_i = tot_i;
        icache_araddr_i = 32'h0000_00C0; icache_ren_i = 1'b1;
        wait_rready("retag");
        cycles(2);
        icache_araddr_i = 32'h0000_0104;
        wait_pulses(1, 0, 60, "retag");
        check_val("retag_line", line_i, make_line(32'h0000_0100, 8));
        check_val("retag_araddr", s_ar_addr, 32'h0000_0100);
        cycles(2);
        check_val("retag_cnt", tot_i - b_i, 1);

        // SLVERR on every beat: data still delivered.
        s_resp = 2'b10;
        icache_araddr_i = 32'h0000_6000; icache_ren_i = 1'b1;
        wait_pulses(1, 0, 30, "slverr");
        check_val("slverr_line", line_i, make_line(32'h0000_6000, 8));
        s_resp = 2'b00;
        cycles(2);

        // Ten beats before rlast: beats 8 and 9 overwrite words 0 and 1.
        s_nbeats = 10;
        dcache_araddr_i = 32'h0000_7000; dcache_ren_i = 1'b1;
        wait_pulses(0, 1, 40, "wrap");
        check_val("wrap_line", line_d,
                  {32'h7007, 32'h7006, 32'h7005, 32'h7004, 32'h7003, 32'h7002, 32'h7009, 32'h7008});
        s_nbeats = 8;
        cycles(2);

        // Reset after three beats.
        b_i = tot_i; b_d = tot_d;
        dcache_araddr_i = 32'h0000_2000; dcache_ren_i = 1'b1;
        wait_rready("midrst");
        cycles(3);
        rst = 1'b1;
        cycles(1);
        check_val("midrst_busy", busy_o, 1'b0);
        check_val("midrst_arvalid", axi.arvalid, 1'b0);
        check_val("midrst_rready", axi.rready, 1'b0);
        check_val("midrst_line", dcache_rdata_o, 256'h0);
        rst = 1'b0; dcache_ren_i = 1'b0;
        cycles(15);
        check_val("midrst_no_pulse", (tot_i - b_i) + (tot_d - b_d), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
